bus_compare_pipe: RTL and testbench

Multi-lane, pipelined successor to the dynamic node's single-cycle bus equality comparator. It compares NUM_LANES pairs of WIDTH-bit operands under per-lane programmable bit masks. Results are produced through a two-stage valid/ready pipeline with per-lane, any and all match flags, plus a saturating full-match counter. It sits between the router's header-extract logic and the route/credit decision logic, where a registered, backpressurable compare is required for timing closure.

---
 rtl/bus_compare_pipe_pkg.sv | 25 ++
 rtl/bus_compare_lane.sv | 14 +
 rtl/bus_compare_pipe.sv | 117 +++++++++++
 tb/tb_bus_compare_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_compare_pipe_pkg.sv
// Shared definitions for the pipelined bus comparator.
// Header-extract logic reuses the lane index width helper, the mask reset
// value and the lane slice macro.
`ifndef BUS_COMPARE_PIPE_PKG_SV
`define BUS_COMPARE_PIPE_PKG_SV

// Lane i of a flat packed bus of w-bit lanes
`define BCP_LANE_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package bus_compare_pipe_pkg;

   // Widest lane supported by the shared mask reset value
   localparam int unsigned MAX_WIDTH = 64;

   // All bits participate in the compare after reset
   localparam logic [MAX_WIDTH-1:0] MASK_RST_VAL = '1;

   // Lane index width, never narrower than one bit
   function automatic int unsigned lane_idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`endif

// File: rtl/bus_compare_lane.sv
// One compare lane: eq is high when a and b agree on every masked-in bit.
// Ports: a, b (operands), mask (1 = bit participates), eq (combinational).
module bus_compare_lane #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] mask,
   output logic             eq
);

   assign eq = ~|((a ^ b) & mask);

endmodule

// File: rtl/bus_compare_pipe.sv
// Multi-lane masked equality compare with a two-stage valid/ready pipeline,
// any/all flags and a saturating full-match counter.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b (operand sets);
// mask_wr_en/mask_wr_lane/mask_wr_data (per-lane mask write);
// out_valid/out_ready/out_equal/out_any/out_all (results);
// match_cnt/cnt_clr (count of transferred all-match results).
module bus_compare_pipe
   import bus_compare_pipe_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned CNT_WIDTH  = 16,
   localparam int unsigned LANE_IDX_W = lane_idx_w(NUM_LANES)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_LANES*WIDTH-1:0] in_a,
   input  logic [NUM_LANES*WIDTH-1:0] in_b,
   input  logic                       mask_wr_en,
   input  logic [LANE_IDX_W-1:0]      mask_wr_lane,
   input  logic [WIDTH-1:0]           mask_wr_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_LANES-1:0]       out_equal,
   output logic                       out_any,
   output logic                       out_all,
   output logic [CNT_WIDTH-1:0]       match_cnt,
   input  logic                       cnt_clr
);

   localparam logic [WIDTH-1:0]     MASK_RST = WIDTH'(MASK_RST_VAL);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   logic [WIDTH-1:0]     mask_q [NUM_LANES];
   logic [NUM_LANES-1:0] eq_c;
   logic [NUM_LANES-1:0] s1_eq;
   logic                 s1_v;
   logic                 s1_ready_c;
   logic                 s2_ready_c;
   logic                 in_xfer_c;
   logic                 out_xfer_c;

   // Per-lane masks; a write lands on the next edge, lanes out of range ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANES; i++) mask_q[i] <= MASK_RST;
      end else if (mask_wr_en) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (mask_wr_lane == LANE_IDX_W'(i)) mask_q[i] <= mask_wr_data;
         end
      end
   end

   // Combinational compare of the incoming operand set against current masks
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      bus_compare_lane #(.WIDTH(WIDTH)) u_lane (
         .a    (`BCP_LANE_SLICE(in_a, g, WIDTH)),
         .b    (`BCP_LANE_SLICE(in_b, g, WIDTH)),
         .mask (mask_q[g]),
         .eq   (eq_c[g])
      );
   end

   // Ready chain: only out_ready propagates combinationally back to in_ready
   always_comb begin
      s2_ready_c = !out_valid || out_ready;
      s1_ready_c = !s1_v || s2_ready_c;
      in_xfer_c  = in_valid && s1_ready_c;
      out_xfer_c = out_valid && out_ready;
   end

   assign in_ready = s1_ready_c;

   // Stage 1: capture the equal vector on input transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v  <= 1'b0;
         s1_eq <= '0;
      end else if (in_xfer_c) begin
         s1_v  <= 1'b1;
         s1_eq <= eq_c;
      end else if (s2_ready_c) begin
         s1_v  <= 1'b0;
      end
   end

   // Stage 2: result registers; data held while stalled or empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_equal <= '0;
         out_any   <= 1'b0;
         out_all   <= 1'b0;
      end else if (s2_ready_c) begin
         out_valid <= s1_v;
         if (s1_v) begin
            out_equal <= s1_eq;
            out_any   <= |s1_eq;
            out_all   <= &s1_eq;
         end
      end
   end

   // Saturating full-match counter; clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         match_cnt <= '0;
      end else if (out_xfer_c && out_all && (match_cnt != CNT_MAX)) begin
         match_cnt <= match_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_bus_compare_pipe.sv
// Directed self-checking bench for bus_compare_pipe (4 lanes x 8 bits,
// 4-bit counter so saturation is reachable quickly).
module tb_bus_compare_pipe;

   localparam int NL = 4;
   localparam int W  = 8;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid;
   logic            in_ready;
   logic [NL*W-1:0] in_a;
   logic [NL*W-1:0] in_b;
   logic            mask_wr_en;
   logic [1:0]      mask_wr_lane;
   logic [W-1:0]    mask_wr_data;
   logic            out_valid;
   logic            out_ready;
   logic [NL-1:0]   out_equal;
   logic            out_any;
   logic            out_all;
   logic [CW-1:0]   match_cnt;
   logic            cnt_clr;

   int n_checks = 0;
   int n_err    = 0;

   logic [W-1:0]  m_mask [NL];
   logic [NL-1:0] sb [$];
   int            exp_cnt;

   always #5 clk = ~clk;

   bus_compare_pipe #(.WIDTH(W), .NUM_LANES(NL), .CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .mask_wr_en   (mask_wr_en),
      .mask_wr_lane (mask_wr_lane),
      .mask_wr_data (mask_wr_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_equal    (out_equal),
      .out_any      (out_any),
      .out_all      (out_all),
      .match_cnt    (match_cnt),
      .cnt_clr      (cnt_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference masked compare using the bench's own mask copy
   function automatic logic [NL-1:0] model_eq(input logic [NL*W-1:0] a, input logic [NL*W-1:0] b);
      logic [NL-1:0] r;
      logic [W-1:0]  x;
      for (int i = 0; i < NL; i++) begin
         x    = (a[i*W +: W] ^ b[i*W +: W]) & m_mask[i];
         r[i] = (x == '0);
      end
      return r;
   endfunction

   initial begin
      logic [NL-1:0] e;
      int            sent;
      int            got;
      logic          need_new;

      in_valid = 1'b0; in_a = '0; in_b = '0;
      mask_wr_en = 1'b0; mask_wr_lane = '0; mask_wr_data = '0;
      out_ready = 1'b1; cnt_clr = 1'b0;
      for (int i = 0; i < NL; i++) m_mask[i] = 8'hFF;
      exp_cnt = 0;

      // Reset values
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_equal", 32'(out_equal), 32'd0);
      chk("rst_out_any",   32'(out_any),   32'd0);
      chk("rst_out_all",   32'(out_all),   32'd0);
      chk("rst_match_cnt", 32'(match_cnt), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      // Only lane 0 equal; result two edges after the transfer
      in_a = 32'h0000_005A; in_b = 32'hFFFF_FF5A; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_not_yet", 32'(out_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_equal", 32'(out_equal), 32'b0001);
      chk("t1_any",   32'(out_any),   32'd1);
      chk("t1_all",   32'(out_all),   32'd0);
      tick();
      chk("t1_cnt",   32'(match_cnt), 32'd0);
      chk("t1_drain", 32'(out_valid), 32'd0);

      // Mask write with a vector in the same cycle: that vector sees the old mask
      in_a = 32'h1122_3C44; in_b = 32'h1122_FC44; in_valid = 1'b1;
      mask_wr_en = 1'b1; mask_wr_lane = 2'd1; mask_wr_data = 8'h0F;
      tick();
      mask_wr_en = 1'b0;
      m_mask[1] = 8'h0F;
      tick();
      in_valid = 1'b0;
      chk("wr_cycle_equal", 32'(out_equal), 32'b1101);
      chk("wr_cycle_all",   32'(out_all),   32'd0);
      tick();
      chk("new_mask_equal", 32'(out_equal), 32'b1111);
      chk("new_mask_all",   32'(out_all),   32'd1);
      chk("new_mask_cnt0",  32'(match_cnt), 32'd0);
      tick();
      chk("new_mask_cnt1",  32'(match_cnt), 32'd1);
      chk("new_mask_drain", 32'(out_valid), 32'd0);

      // Stall: two entries fill, then in_ready drops; release restores in order
      out_ready = 1'b0;
      in_a = 32'h1122_3344; in_b = 32'h1122_3344; in_valid = 1'b1;
      #1 chk("stall_rdy1", 32'(in_ready), 32'd1);
      tick();
      in_b = 32'h1122_33FF;
      chk("stall_rdy2", 32'(in_ready), 32'd1);
      tick();
      in_b = 32'hFF22_3344;
      chk("stall_rdy3",  32'(in_ready),  32'd0);
      chk("stall_hold1", 32'(out_equal), 32'b1111);
      tick();
      chk("stall_rdy4",  32'(in_ready),  32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_hold2", 32'(out_equal), 32'b1111);
      out_ready = 1'b1;
      #1 chk("release_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("release_cnt", 32'(match_cnt), 32'd2);
      chk("release_x2",  32'(out_equal), 32'b1110);
      tick();
      chk("release_x3",  32'(out_equal), 32'b0111);
      tick();
      chk("release_drain", 32'(out_valid), 32'd0);
      exp_cnt = 2;

      // Random backpressure against a scoreboard
      sent = 0; got = 0; need_new = 1'b1;
      for (int cyc = 0; cyc < 3000 && got < 60; cyc++) begin
         if (need_new) begin
            in_a = $urandom;
            in_b = in_a ^ ($urandom & $urandom & $urandom);
            need_new = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 60);
         #1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("rand_extra", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rand_equal", 32'(out_equal), 32'(e));
               chk("rand_all",   32'(out_all),   32'(&e));
               if ((&e) && exp_cnt < 15) exp_cnt++;
            end
            got++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(model_eq(in_a, in_b));
            sent++;
            need_new = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("rand_count", 32'(got), 32'd60);
      chk("rand_cnt",   32'(match_cnt), 32'(exp_cnt));

      // Saturation after 20 all-match transfers
      out_ready = 1'b1; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_only", 32'(match_cnt), 32'd0);
      in_a = '0; in_b = '0; in_valid = 1'b1;
      repeat (20) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("sat_cnt", 32'(match_cnt), 32'd15);

      // Clear beats a simultaneous all-match transfer
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("clr_win_valid", 32'(out_valid & out_all), 32'd1);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_win_cnt", 32'(match_cnt), 32'd0);

      // Async reset with both stages full
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("pre_rst_cnt", 32'(match_cnt), 32'd1);
      out_ready = 1'b0; in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      chk("full_valid", 32'(out_valid), 32'd1);
      chk("full_rdy",   32'(in_ready),  32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_cnt",   32'(match_cnt), 32'd0);
      chk("arst_equal", 32'(out_equal), 32'd0);
      for (int i = 0; i < NL; i++) m_mask[i] = 8'hFF;
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_rst_rdy", 32'(in_ready), 32'd1);
      in_a = 32'h1122_3C44; in_b = 32'h1122_FC44; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      e = model_eq(32'h1122_3C44, 32'h1122_FC44);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_mask",  32'(out_equal), 32'b1101);
      chk("post_rst_model", 32'(out_equal), 32'(e));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
